// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers (MIPS-style MDU).
// Define E_MDU_MADD_EN to build in the MADD/MADDU/MSUB/MSUBU accumulate ops.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hl_sel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] HL_data
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;

  logic is_mul_op, is_div_op, launch, last_cycle;
  logic op_signed;
  logic [63:0] a_ext, b_ext, prod, result;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  logic        a_neg, b_neg;

  always_comb begin
    is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
`ifdef E_MDU_MADD_EN
    is_mul_op = is_mul_op || (op == OP_MADD) || (op == OP_MADDU) ||
                (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    is_div_op = (op == OP_DIV) || (op == OP_DIVU);
  end

  assign launch     = start && (state_q == S_IDLE) && (is_mul_op || is_div_op);
  assign last_cycle = (state_q == S_RUN) && (cnt_q == CW'(1));

  // Datapath works on the latched operands; HI/LO cannot change while busy,
  // so the live hi_q/lo_q double as the accumulator snapshot taken at start.
  assign op_signed = (op_q == OP_MULT) || (op_q == OP_DIV) ||
                     (op_q == OP_MADD) || (op_q == OP_MSUB);
  assign a_ext = {{32{a_q[31] & op_signed}}, a_q};
  assign b_ext = {{32{b_q[31] & op_signed}}, b_q};
  assign prod  = a_ext * b_ext;

  // Signed division via magnitudes; -2^31 / -1 wraps back to 0x80000000.
  assign a_neg = op_signed && a_q[31];
  assign b_neg = op_signed && b_q[31];
  assign a_mag = a_neg ? (~a_q + 32'd1) : a_q;
  assign b_mag = b_neg ? (~b_q + 32'd1) : b_q;
  assign q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
  assign r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
  assign quot  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem   = a_neg ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    result = {hi_q, lo_q};
    case (op_q)
      OP_MULT, OP_MULTU: result = prod;
      OP_DIV, OP_DIVU:   if (b_q != 32'd0) result = {rem, quot};
`ifdef E_MDU_MADD_EN
      OP_MADD, OP_MADDU: result = {hi_q, lo_q} + prod;
      OP_MSUB, OP_MSUBU: result = {hi_q, lo_q} - prod;
`endif
      default:           result = {hi_q, lo_q};
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (launch) state_d = S_RUN;
      S_RUN:   if (last_cycle) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy    = (state_q == S_RUN);
    HL_data = hl_sel ? hi_q : lo_q;
  end

  assign hi = hi_q;
  assign lo = lo_q;

  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (launch) begin
      cnt_d = is_div_op ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      op_d  = op;
      a_d   = a;
      b_d   = b;
    end else if (state_q == S_RUN) begin
      cnt_d = cnt_q - CW'(1);
      if (last_cycle) {hi_d, lo_d} = result;
    end
    if (start && (state_q == S_IDLE)) begin
      if (op == OP_MTHI) hi_d = a;
      if (op == OP_MTLO) lo_d = a;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Randomised self-checking bench for e_mdu with a plain-arithmetic HI/LO model.
// Honours E_MDU_MADD_EN the same way as the design.
module tb_e_mdu;

  logic        clk, rst, start, hl_sel;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo, HL_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_hi, m_lo;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hl_sel(hl_sel), .busy(busy), .hi(hi), .lo(lo), .HL_data(HL_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit madd_en();
`ifdef E_MDU_MADD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int exp_cycles(input logic [3:0] o);
    if (o <= 4'd1) return 5;
    if (o == 4'd2 || o == 4'd3) return 10;
    if (o >= 4'd6 && o <= 4'd9 && madd_en()) return 5;
    return 0;
  endfunction

  // Reference behaviour: what HI/LO become after op o with operands x, y.
  task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int          sx, sy, q, r;
    longint      sp;
    logic [63:0] up, acc;
    sx = x;
    sy = y;
    sp = longint'(sx) * longint'(sy);
    up = 64'(x) * 64'(y);
    acc = {m_hi, m_lo};
    case (o)
      4'd0: {m_hi, m_lo} = sp;
      4'd1: {m_hi, m_lo} = up;
      4'd2: if (y != 0) begin
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000;
          m_hi = 32'h0;
        end else begin
          q = sx / sy;
          r = sx % sy;
          m_lo = q;
          m_hi = r;
        end
      end
      4'd3: if (y != 0) begin
        m_lo = x / y;
        m_hi = x % y;
      end
      4'd4: m_hi = x;
      4'd5: m_lo = x;
      4'd6: if (madd_en()) {m_hi, m_lo} = acc + sp;
      4'd7: if (madd_en()) {m_hi, m_lo} = acc + up;
      4'd8: if (madd_en()) {m_hi, m_lo} = acc - sp;
      4'd9: if (madd_en()) {m_hi, m_lo} = acc - up;
      default: ;
    endcase
  endtask

  // Enter and leave at a negedge. Optionally fires a second start mid-op.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit intr, input logic [3:0] iop);
    int n;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 60) begin
      if (intr && n == 2) begin
        start = 1'b1; op = iop; a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    model(o, x, y);
    check("busy_cycles", 64'(n), 64'(exp_cycles(o)));
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
    hl_sel = 1'($urandom);
    #1;
    check("hl_data", 64'(HL_data), 64'(hl_sel ? m_hi : m_lo));
    $display("[TB] op=%0d a=%h b=%h busy_cycles=%0d hi=%h lo=%h", o, x, y, n, hi, lo);
  endtask

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0; hl_sel = 1'b0;
    m_hi = '0; m_lo = '0;
    #1;
    check("rst_hi", 64'(hi), 64'h0);
    check("rst_lo", 64'(lo), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);

    // A start presented while reset is held must be ignored.
    @(negedge clk);
    start = 1'b1; op = 4'd5; a = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("start_in_rst_lo", 64'(lo), 64'h0);

    run_op(4'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 4'd0);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFFA);

    run_op(4'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 4'd0);
    check("div_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(hi), 64'hFFFF_FFFF);
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 4'd0);
    check("divu_lo", 64'(lo), 64'h7FFF_FFFC);
    check("divu_hi", 64'(hi), 64'h1);
    run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 4'd0);
    check("div_ovf_lo", 64'(lo), 64'h8000_0000);
    check("div_ovf_hi", 64'(hi), 64'h0);

    run_op(4'd5, 32'h1234_5678, 32'd0, 1'b0, 4'd0);
    hl_sel = 1'b0;
    #1;
    check("mtlo_hl", 64'(HL_data), 64'h1234_5678);
    run_op(4'd3, 32'd99, 32'd0, 1'b0, 4'd0);
    check("divz_lo", 64'(lo), 64'h1234_5678);

    // Starts during a DIV are ignored; the following MULTU goes back-to-back.
    run_op(4'd2, 32'd1000, 32'd7, 1'b1, 4'd1);
    run_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd0);
    run_op(4'd0, 32'd12, 32'd13, 1'b1, 4'd4);

    run_op(4'd4, 32'h0, 32'd0, 1'b0, 4'd0);
    run_op(4'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 4'd0);
    run_op(4'd7, 32'd1, 32'd1, 1'b0, 4'd0);
    check("maddu_hi", 64'(hi), madd_en() ? 64'h1 : 64'h0);
    check("maddu_lo", 64'(lo), madd_en() ? 64'h0 : 64'hFFFF_FFFF);
    run_op(4'd12, 32'd5, 32'd5, 1'b0, 4'd0);

    // Asynchronous reset in the middle of a MULT.
    run_op(4'd1, 32'd7, 32'd9, 1'b0, 4'd0);
    start = 1'b1; op = 4'd0; a = 32'hFFFF_FFFF; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'h0);
    check("arst_hi", 64'(hi), 64'h0);
    check("arst_lo", 64'(lo), 64'h0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("arst_nowrite_hi", 64'(hi), 64'h0);
    check("arst_nowrite_lo", 64'(lo), 64'h0);
    check("arst_nowrite_busy", 64'(busy), 64'h0);

    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = {28'd0, 4'($urandom)};
      run_op(ro, ra, rb, ($urandom_range(0, 4) == 0), 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
